// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_HALT_DETECT_EN adds the HALT state used
// when fetch stops on a branch-to-self instruction.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
`ifdef FETCH_HALT_DETECT_EN
    ,
    ST_HALT = 2'd2
`endif
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP       = 32'd0;
  localparam logic [31:0] INSTR_SELF_LOOP = 32'hEAFF_FFFE;
  localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register set: instruction word, fetch address + 4 and a
// valid flag. Flush has priority over load; with neither asserted it holds.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Capture a new instruction, squash to a bubble on flush, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= INSTR_NOP;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= INSTR_NOP;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN control FSM, delivered
// instruction counter and the IF/ID register. The memory address is the PC
// register itself, so stall/branch never reach imem_adr_o combinationally.
// Optional feature macro: FETCH_HALT_DETECT_EN stops fetch in HALT once a
// branch-to-self word (INSTR_SELF_LOOP) has been delivered.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_addr_i,
  output logic [31:0]      imem_adr_o,
  input  logic [31:0]      imem_rd_i,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             halted_o
);

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic             w_run;
  logic             w_branch;
  logic             w_advance;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_target;

  // Branches win over stalls; nothing moves outside RUN.
  assign w_run           = (r_state == ST_RUN);
  assign w_branch        = w_run && branch_taken_i;
  assign w_advance       = w_run && !branch_taken_i && !stall_i;
  assign w_pc_plus4      = r_pc + PC_STEP;
  assign w_branch_target = branch_addr_i & ~32'd3;

`ifdef FETCH_HALT_DETECT_EN
  logic w_halt_hit;
  assign w_halt_hit = w_advance && (imem_rd_i == INSTR_SELF_LOOP);
`endif

  // Control FSM: leave BOOT on the first edge after reset, optionally park in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else if (r_state == ST_BOOT) begin
      r_state <= ST_RUN;
`ifdef FETCH_HALT_DETECT_EN
    end else if (w_halt_hit) begin
      r_state <= ST_HALT;
`endif
    end
  end

  // Program counter: redirect on branch, step by four on a normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_branch) begin
      r_pc <= w_branch_target;
    end else if (w_advance) begin
      r_pc <= w_pc_plus4;
    end
  end

  // Count every instruction handed to ID; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
    end else if (w_advance) begin
      r_fetch_cnt <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_advance),
    .i_flush (w_branch),
    .i_instr (imem_rd_i),
    .i_pc4   (w_pc_plus4),
    .o_instr (if_id_instr_o),
    .o_pc4   (if_id_pc4_o),
    .o_valid (if_id_valid_o)
  );

  assign imem_adr_o  = r_pc;
  assign fetch_cnt_o = r_fetch_cnt;

`ifdef FETCH_HALT_DETECT_EN
  assign halted_o = (r_state == ST_HALT);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A behavioural memory answers
// every address; a transaction-level model of the fetch rules predicts the
// outputs after each clock edge. Honours FETCH_HALT_DETECT_EN if defined.
module tb_instruction_fetch;

  localparam int          TB_CNT_W   = 4;
  localparam logic [31:0] TB_RST_PC  = 32'd0;
  localparam logic [31:0] SELF_LOOP  = 32'hEAFF_FFFE;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit          HALT_EN    = 1'b1;
`else
  localparam bit          HALT_EN    = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                stall_i;
  logic                branch_taken_i;
  logic [31:0]         branch_addr_i;
  logic [31:0]         imem_adr_o;
  logic [31:0]         imem_rd_i;
  logic [31:0]         if_id_instr_o;
  logic [31:0]         if_id_pc4_o;
  logic                if_id_valid_o;
  logic [TB_CNT_W-1:0] fetch_cnt_o;
  logic                halted_o;

  // Memory contents: address XOR a pattern, with an optional self-loop at 184.
  logic [31:0] memXor;
  logic        haltWordEn;

  // Reference model state.
  bit          mRun;
  bit          mHalted;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;
  int          mCnt;

  int checkCount;
  int errorCount;

  instruction_fetch #(
    .RESET_PC (TB_RST_PC),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_addr_i  (branch_addr_i),
    .imem_adr_o     (imem_adr_o),
    .imem_rd_i      (imem_rd_i),
    .if_id_instr_o  (if_id_instr_o),
    .if_id_pc4_o    (if_id_pc4_o),
    .if_id_valid_o  (if_id_valid_o),
    .fetch_cnt_o    (fetch_cnt_o),
    .halted_o       (halted_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational instruction memory.
  always_comb begin
    imem_rd_i = imem_adr_o ^ memXor;
    if (haltWordEn && imem_adr_o == 32'd184) imem_rd_i = SELF_LOOP;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (haltWordEn && a == 32'd184) return SELF_LOOP;
    return a ^ memXor;
  endfunction

  task automatic modelReset();
    mRun    = 1'b0;
    mHalted = 1'b0;
    mPc     = TB_RST_PC;
    mInstr  = 32'd0;
    mPc4    = 32'd0;
    mValid  = 1'b0;
    mCnt    = 0;
  endtask

  // One clock edge of the fetch rules, using the inputs presented before it.
  task automatic modelEdge(input logic stall, input logic br, input logic [31:0] addr);
    logic [31:0] word;
    if (!mRun) begin
      mRun = 1'b1;
    end else if (mHalted) begin
      mRun = 1'b1;
    end else if (br) begin
      mPc    = {addr[31:2], 2'b00};
      mValid = 1'b0;
      mInstr = 32'd0;
    end else if (!stall) begin
      word   = memWord(mPc);
      mInstr = word;
      mPc4   = mPc + 32'd4;
      mPc    = mPc + 32'd4;
      mValid = 1'b1;
      mCnt   = (mCnt + 1) % (1 << TB_CNT_W);
      if (HALT_EN && word == SELF_LOOP) mHalted = 1'b1;
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string phase);
    checkField({phase, ".imem_adr"},  imem_adr_o,                  mPc);
    checkField({phase, ".instr"},     if_id_instr_o,               mInstr);
    checkField({phase, ".pc4"},       if_id_pc4_o,                 mPc4);
    checkField({phase, ".valid"},     {31'd0, if_id_valid_o},      {31'd0, mValid});
    checkField({phase, ".fetch_cnt"}, {28'd0, fetch_cnt_o},        32'(mCnt));
    checkField({phase, ".halted"},    {31'd0, halted_o},           {31'd0, mHalted});
  endtask

  // Drive inputs for one cycle, let the edge happen, then compare.
  task automatic applyStimulus(input string phase, input logic stall, input logic br,
                               input logic [31:0] addr);
    stall_i        = stall;
    branch_taken_i = br;
    branch_addr_i  = addr;
    modelEdge(stall, br, addr);
    @(posedge clk);
    #1;
    checkOutput(phase);
  endtask

  // Assert reset between edges, check the cleared outputs, release at a falling edge.
  task automatic doReset(input string phase);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(phase);
    @(negedge clk);
    rst_n          = 1'b1;
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_addr_i  = 32'd0;
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    memXor         = 32'd0;
    haltWordEn     = 1'b0;
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_addr_i  = 32'd0;
    rst_n          = 1'b0;
    modelReset();
    $display("[TB] start, halt detect = %0d", HALT_EN);

    // Reset state and release; memory returns address as data.
    #2;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("boot", 1'b0, 1'b0, 32'd0);
    applyStimulus("run1", 1'b0, 1'b0, 32'd0);
    applyStimulus("run2", 1'b0, 1'b0, 32'd0);
    applyStimulus("run3", 1'b0, 1'b0, 32'd0);
    applyStimulus("run4", 1'b0, 1'b0, 32'd0);

    // Stall three cycles at pc 16, then resume.
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b0, 32'd0);
    applyStimulus("unstall", 1'b0, 1'b0, 32'd0);
    applyStimulus("unstall2", 1'b0, 1'b0, 32'd0);

    // Branch and stall together: the branch wins and the target is word aligned.
    applyStimulus("br_stall", 1'b1, 1'b1, 32'h0000_0073);
    applyStimulus("after_br", 1'b0, 1'b0, 32'd0);
    applyStimulus("after_br2", 1'b0, 1'b0, 32'd0);

    // PC wraps modulo 2^32.
    applyStimulus("br_top", 1'b0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus("wrap", 1'b0, 1'b0, 32'd0);
    applyStimulus("wrap2", 1'b0, 1'b0, 32'd0);

    // Randomised traffic; the 4-bit counter wraps many times here.
    memXor = $urandom;
    for (int i = 0; i < 300; i++) begin
      logic rs;
      logic rb;
      rs = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 7) == 0);
      applyStimulus("random", rs, rb, $urandom);
    end

    // Self-loop word at 184.
    memXor     = 32'd0;
    haltWordEn = 1'b1;
    #3;
    doReset("rst_pre_halt");
    applyStimulus("h_boot", 1'b0, 1'b0, 32'd0);
    applyStimulus("h_br", 1'b0, 1'b1, 32'd184);
    applyStimulus("h_hit", 1'b0, 1'b0, 32'd0);
    applyStimulus("h_next", 1'b0, 1'b0, 32'd0);
    applyStimulus("h_br_ign", 1'b0, 1'b1, 32'h0000_0040);
    applyStimulus("h_stall", 1'b1, 1'b0, 32'd0);
    applyStimulus("h_run", 1'b0, 1'b0, 32'd0);
    #3;
    doReset("rst_halt");
    haltWordEn = 1'b0;
    applyStimulus("r_boot", 1'b0, 1'b0, 32'd0);
    applyStimulus("r_run", 1'b0, 1'b0, 32'd0);
    applyStimulus("r_run2", 1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges while stalled.
    applyStimulus("pre_stall", 1'b1, 1'b0, 32'd0);
    applyStimulus("pre_stall2", 1'b1, 1'b0, 32'd0);
    #2;
    doReset("async_rst");
    applyStimulus("a_boot", 1'b0, 1'b0, 32'd0);
    applyStimulus("a_run", 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
